// File: rtl/memory_controller_pkg.sv
// Shared definitions for the memory controller: bus width selection and FSM encoding.
package memory_controller_pkg;

`ifdef RV64I
  localparam int XLEN = 64;
`else
  localparam int XLEN = 32;
`endif

  localparam int BYTE_NUM = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROM_ACC = 2'd1,
    RAM_ACC = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/memory_controller_if.sv
// Core request bus plus ROM/RAM device buses; master drives requests and device replies.
interface memory_controller_if
  import memory_controller_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = XLEN
);
  logic                  mem_rd_en;
  logic                  mem_wr_en;
  logic [DATA_W/8-1:0]   mem_byte_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W-1:0]     rd_data;
  logic                  mem_busy;
  logic                  bus_error;

  logic                  rom_en;
  logic [ADDR_W-1:0]     rom_addr;
  logic [DATA_W-1:0]     rom_rd_data;
  logic                  rom_ack;

  logic                  ram_en;
  logic                  ram_wr;
  logic [DATA_W/8-1:0]   ram_byte_en;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wr_data;
  logic [DATA_W-1:0]     ram_rd_data;
  logic                  ram_ack;

  modport master (
    output mem_rd_en, mem_wr_en, mem_byte_en, mem_addr, wr_data,
    output rom_rd_data, rom_ack, ram_rd_data, ram_ack,
    input  rd_data, mem_busy, bus_error,
    input  rom_en, rom_addr, ram_en, ram_wr, ram_byte_en, ram_addr, ram_wr_data
  );

  modport slave (
    input  mem_rd_en, mem_wr_en, mem_byte_en, mem_addr, wr_data,
    input  rom_rd_data, rom_ack, ram_rd_data, ram_ack,
    output rd_data, mem_busy, bus_error,
    output rom_en, rom_addr, ram_en, ram_wr, ram_byte_en, ram_addr, ram_wr_data
  );
endinterface

// File: rtl/memory_controller_byte_lane_align.sv
// Moves LSB-justified core data onto word lanes for the device, and device data back
// down to LSB-justified, zero-extended load data.
module byte_lane_align
  import memory_controller_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [OFF_W-1:0]    offset,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W-1:0]   dev_rd_data,
  output logic [DATA_W/8-1:0] dev_byte_en,
  output logic [DATA_W-1:0]   dev_wr_data,
  output logic [DATA_W-1:0]   rd_data
);
  localparam int BN = DATA_W / 8;

  logic [OFF_W+2:0]  bit_shift;
  logic [DATA_W-1:0] lane_mask;

  assign bit_shift   = {offset, 3'b000};
  assign dev_byte_en = byte_en << offset;
  assign dev_wr_data = wr_data << bit_shift;

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BN; i++) lane_mask[i*8 +: 8] = {8{byte_en[i]}};
  end

  assign rd_data = (dev_rd_data >> bit_shift) & lane_mask;
endmodule

// File: rtl/memory_controller.sv
// Single-outstanding memory controller: decodes core requests to ROM or RAM, waits for
// the device ack with a timeout, and flags illegal or failed accesses on a sticky error.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int          DATA_W   = XLEN,
  parameter int          ADDR_W   = XLEN,
  parameter int unsigned RAM_BASE = 32'h1000,
  parameter int          TIMEOUT  = 15
) (
  input logic                clock,
  input logic                reset,
  memory_controller_if.slave bus
);
  localparam int BN    = DATA_W / 8;
  localparam int OFF_W = $clog2(BN);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // True when the access would spill past the top byte lane of the word.
  function automatic logic misaligned(input logic [BN-1:0] be, input logic [OFF_W-1:0] off);
    logic [2*BN-1:0] span;
    span = {{BN{1'b0}}, be} << off;
    return |span[2*BN-1:BN];
  endfunction

  state_t            state, state_nxt;
  logic              armed;
  logic              accept, err_set, capture;
  logic              rom_hit, dev_ack, tmo_hit, in_access;
  logic [DATA_W-1:0] dev_rd;

  logic [ADDR_W-1:0] addr_p0;
  logic [BN-1:0]     be_p0;
  logic [DATA_W-1:0] wd_p0;
  logic              wr_p0;
  logic [CNT_W-1:0]  tmo_cnt;

  logic              busy_p1;
  logic              err_p1;
  logic [DATA_W-1:0] rd_data_p1;

  logic [BN-1:0]     lane_be;
  logic [DATA_W-1:0] lane_wd;
  logic [DATA_W-1:0] lane_rd;

  assign rom_hit   = bus.mem_addr < ADDR_W'(RAM_BASE);
  assign in_access = (state == ROM_ACC) || (state == RAM_ACC);
  assign dev_ack   = (state == ROM_ACC) ? bus.rom_ack : bus.ram_ack;
  assign dev_rd    = (state == ROM_ACC) ? bus.rom_rd_data : bus.ram_rd_data;
  assign tmo_hit   = tmo_cnt == CNT_W'(TIMEOUT - 1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    err_set   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && (bus.mem_rd_en || bus.mem_wr_en)) begin
          if ((bus.mem_rd_en && bus.mem_wr_en) ||
              misaligned(bus.mem_byte_en, bus.mem_addr[OFF_W-1:0]) ||
              (bus.mem_wr_en && rom_hit)) begin
            err_set   = 1'b1;
            state_nxt = DONE;
          end else begin
            accept    = 1'b1;
            state_nxt = rom_hit ? ROM_ACC : RAM_ACC;
          end
        end
      end
      ROM_ACC, RAM_ACC: begin
        if (dev_ack) begin
          capture   = !wr_p0;
          state_nxt = DONE;
        end else if (tmo_hit) begin
          err_set   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch / access stage; armed blocks acceptance on the first edge after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed      <= 1'b0;
      busy_p1    <= 1'b0;
      err_p1     <= 1'b0;
      rd_data_p1 <= '0;
      addr_p0    <= '0;
      be_p0      <= '0;
      wd_p0      <= '0;
      wr_p0      <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      armed   <= 1'b1;
      busy_p1 <= (state_nxt == ROM_ACC) || (state_nxt == RAM_ACC);
      if (err_set) err_p1 <= 1'b1;
      if (accept) begin
        addr_p0 <= bus.mem_addr;
        be_p0   <= bus.mem_byte_en;
        wd_p0   <= bus.wr_data;
        wr_p0   <= bus.mem_wr_en;
        tmo_cnt <= '0;
      end else if (in_access) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
      if (capture) rd_data_p1 <= lane_rd;
    end
  end

  byte_lane_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
    .offset      (addr_p0[OFF_W-1:0]),
    .byte_en     (be_p0),
    .wr_data     (wd_p0),
    .dev_rd_data (dev_rd),
    .dev_byte_en (lane_be),
    .dev_wr_data (lane_wd),
    .rd_data     (lane_rd)
  );

  // Device stage: enables follow the access state so they drop the cycle after ack or timeout.
  assign bus.rom_en      = state == ROM_ACC;
  assign bus.ram_en      = state == RAM_ACC;
  assign bus.ram_wr      = (state == RAM_ACC) && wr_p0;
  assign bus.rom_addr    = {addr_p0[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.ram_addr    = {addr_p0[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.ram_byte_en = lane_be;
  assign bus.ram_wr_data = lane_wd;
  assign bus.rd_data     = rd_data_p1;
  assign bus.mem_busy    = busy_p1;
  assign bus.bus_error   = err_p1;
endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: stimulus queues expected results, a negedge
// monitor emulates the ROM/RAM devices and scores each completed access.
module tb_memory_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  memory_controller_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  memory_controller #(
    .DATA_W(32), .ADDR_W(32), .RAM_BASE(32'h1000), .TIMEOUT(15)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          busy_cyc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          wr_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;
  int          busy_total = 0;
  int          en_total   = 0;
  int          ack_delay  = 0;
  bit          ack_never  = 1'b0;
  logic [31:0] dev_data   = '0;

  int          en_cyc = 0, busy_cyc = 0, wr_cyc = 0;
  logic        prev_busy = 1'b0;
  logic        ack;
  logic [31:0] s_addr = '0, s_wd = '0;
  logic [3:0]  s_be = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Device model and scoreboard monitor.
  initial begin
    exp_t e;
    bus.rom_ack = 1'b0; bus.ram_ack = 1'b0;
    bus.rom_rd_data = '0; bus.ram_rd_data = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        en_cyc = 0; busy_cyc = 0; wr_cyc = 0; prev_busy = 1'b0;
        s_addr = '0; s_be = '0; s_wd = '0;
        bus.rom_ack = 1'b0; bus.ram_ack = 1'b0;
      end else begin
        if (bus.mem_busy) begin busy_cyc++; busy_total++; end
        if (bus.rom_en || bus.ram_en) begin en_cyc++; en_total++; end
        if (bus.ram_wr) wr_cyc++;
        if (bus.rom_en) s_addr = bus.rom_addr;
        if (bus.ram_en) begin
          s_addr = bus.ram_addr; s_be = bus.ram_byte_en; s_wd = bus.ram_wr_data;
        end
        if (prev_busy && !bus.mem_busy) begin
          n_done++;
          if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_completion: got a finished access, expected none");
          end else begin
            e = sb_q.pop_front();
            check("rd_data",     bus.rd_data,          e.rd);
            check("bus_error",   32'(bus.bus_error),   32'(e.err));
            check("busy_cycles", 32'(busy_cyc),        32'(e.busy_cyc));
            check("en_cycles",   32'(en_cyc),          32'(e.busy_cyc));
            check("dev_addr",    s_addr,               e.addr);
            check("ram_byte_en", 32'(s_be),            32'(e.be));
            check("ram_wr_data", s_wd,                 e.wd);
            check("ram_wr_cyc",  32'(wr_cyc),          32'(e.wr_cyc));
          end
          en_cyc = 0; busy_cyc = 0; wr_cyc = 0;
          s_addr = '0; s_be = '0; s_wd = '0;
        end
        prev_busy = bus.mem_busy;
        ack = !ack_never && (bus.rom_en || bus.ram_en) && (en_cyc == ack_delay + 1);
        bus.rom_ack = bus.rom_en && ack;
        bus.ram_ack = bus.ram_en && ack;
        bus.rom_rd_data = dev_data;
        bus.ram_rd_data = dev_data;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  32'(bus.mem_busy),    32'h0);
    check({tag, "_err"},   32'(bus.bus_error),   32'h0);
    check({tag, "_rd"},    bus.rd_data,          32'h0);
    check({tag, "_romen"}, 32'(bus.rom_en),      32'h0);
    check({tag, "_ramen"}, 32'(bus.ram_en),      32'h0);
    check({tag, "_ramwr"}, 32'(bus.ram_wr),      32'h0);
    check({tag, "_roma"},  bus.rom_addr,         32'h0);
    check({tag, "_rama"},  bus.ram_addr,         32'h0);
    check({tag, "_be"},    32'(bus.ram_byte_en), 32'h0);
    check({tag, "_wd"},    bus.ram_wr_data,      32'h0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clock); #2;
    reset = 1'b0;
    #1 check_zero(tag);
    @(posedge clock); #2;
    reset = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic request(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
    @(posedge clock); #1;
    bus.mem_rd_en = rd; bus.mem_wr_en = wr;
    bus.mem_addr = addr; bus.mem_byte_en = be; bus.wr_data = wd;
    @(posedge clock); #1;
    bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0;
    bus.mem_addr = 32'hFFFF_FFFC; bus.mem_byte_en = 4'h1; bus.wr_data = 32'h5555_5555;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input exp_t e);
    int d0, k;
    d0 = n_done;
    sb_q.push_back(e);
    request(rd, wr, addr, be, wd);
    k = 0;
    while (n_done == d0 && k < 40) begin @(posedge clock); k++; end
    if (n_done == d0) begin
      n_tests++; n_fail++;
      $display("FAIL completion_wait: got no completion in 40 cycles, expected one");
    end
    repeat (2) @(posedge clock);
  endtask

  task automatic no_access_err(input string tag, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [3:0] be);
    int b0, e0;
    b0 = busy_total; e0 = en_total;
    request(rd, wr, addr, be, 32'h0);
    repeat (3) @(posedge clock); #1;
    check({tag, "_err"},  32'(bus.bus_error), 32'h1);
    check({tag, "_busy"}, 32'(busy_total),    32'(b0));
    check({tag, "_en"},   32'(en_total),      32'(e0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0;
    bus.mem_addr = '0; bus.mem_byte_en = '0; bus.wr_data = '0;
    repeat (2) @(posedge clock); #1;
    check_zero("por");
    @(posedge clock); #2;
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // ROM word read with ack two cycles after enable.
    dev_data = 32'hDEADBEEF; ack_delay = 2;
    access(1, 0, 32'h4, 4'hF, 32'h0,
           '{rd: 32'hDEADBEEF, err: 0, busy_cyc: 3, addr: 32'h4, be: 4'h0, wd: 32'h0, wr_cyc: 0});

    // RAM byte store on the top lane; load data must stay as before.
    ack_delay = 1;
    access(0, 1, 32'h1003, 4'h1, 32'h0000_00AB,
           '{rd: 32'hDEADBEEF, err: 0, busy_cyc: 2, addr: 32'h1000, be: 4'h8, wd: 32'hAB00_0000, wr_cyc: 2});

    dev_data = 32'h12345678; ack_delay = 0;
    access(1, 0, 32'h1002, 4'h3, 32'h0,
           '{rd: 32'h0000_1234, err: 0, busy_cyc: 1, addr: 32'h1000, be: 4'hC, wd: 32'h0, wr_cyc: 0});
    access(1, 0, 32'h1001, 4'h1, 32'h0,
           '{rd: 32'h0000_0056, err: 0, busy_cyc: 1, addr: 32'h1000, be: 4'h2, wd: 32'h0, wr_cyc: 0});

    dev_data = 32'hCAFEF00D; ack_delay = 3;
    access(1, 0, 32'h1004, 4'hF, 32'h0,
           '{rd: 32'hCAFEF00D, err: 0, busy_cyc: 4, addr: 32'h1004, be: 4'hF, wd: 32'h0, wr_cyc: 0});
    ack_delay = 0;
    access(0, 1, 32'h1008, 4'hF, 32'h1122_3344,
           '{rd: 32'hCAFEF00D, err: 0, busy_cyc: 1, addr: 32'h1008, be: 4'hF, wd: 32'h1122_3344, wr_cyc: 1});

    // Requests rejected before any device access.
    no_access_err("misalign", 1, 0, 32'h1003, 4'h3);
    do_reset("rst1");
    no_access_err("romwr", 0, 1, 32'h8, 4'hF);
    do_reset("rst2");
    no_access_err("rdwr", 1, 1, 32'h1000, 4'hF);
    do_reset("rst3");

    // Unanswered RAM read times out; a following ROM read proves the FSM is back in IDLE.
    ack_never = 1'b1;
    access(1, 0, 32'h1000, 4'hF, 32'h0,
           '{rd: 32'h0, err: 1, busy_cyc: 15, addr: 32'h1000, be: 4'hF, wd: 32'h0, wr_cyc: 0});
    ack_never = 1'b0; dev_data = 32'h0BADCAFE;
    access(1, 0, 32'h0, 4'hF, 32'h0,
           '{rd: 32'h0BADCAFE, err: 1, busy_cyc: 1, addr: 32'h0, be: 4'h0, wd: 32'h0, wr_cyc: 0});

    // Reset in the middle of a RAM access, then a clean ROM read.
    do_reset("rst4");
    ack_never = 1'b1;
    request(1, 0, 32'h1000, 4'hF, 32'h0);
    repeat (4) @(posedge clock);
    do_reset("midacc");
    ack_never = 1'b0; dev_data = 32'h13572468; ack_delay = 1;
    access(1, 0, 32'hC, 4'hF, 32'h0,
           '{rd: 32'h13572468, err: 0, busy_cyc: 2, addr: 32'hC, be: 4'h0, wd: 32'h0, wr_cyc: 0});

    check("sb_left", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
